// File: rtl/vram_bus_writer.sv
// -----------------------------------------------------------------------------
// vram_bus_writer
//
// CPU-side access port for the two graphics memories. VRAM32 holds patterns and
// palettes, VRAM8 holds name and palette-index tables. The frame synthesizer
// reads the other port of each memory continuously. This block owns the write
// port of each memory. It serves single-word reads and writes, and block fills,
// over a start/busy/done handshake.
//
// Parameters
//   SYNC_VBLANK  1: write beats are issued only while ontile_v is low.
//
// Ports
//   clk, reset          system clock; asynchronous active-high reset
//   bus_start           request strobe, sampled only while idle
//   bus_we              1 = write, 0 = read (ignored for fills)
//   bus_fill            block fill (implies write)
//   bus_addr[11:0]      [11] target (0 = VRAM32, 1 = VRAM8), [10:0] word/base
//   bus_data[31:0]      write/fill data (VRAM8 uses [7:0])
//   bus_count[10:0]     fill length in words (0 = no writes)
//   bus_q[31:0]         read result, VRAM8 zero-extended
//   busy, done          handshake status; done is a one-cycle pulse
//   ontile_v            frame synthesizer is on tile rows
//   vram32_*            VRAM32 port: addr, d, we out, q in (1-cycle read)
//   vram8_*             VRAM8 port: addr, d, we out, q in (1-cycle read)
// -----------------------------------------------------------------------------
module vram_bus_writer #(
    parameter bit SYNC_VBLANK = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_start,
    input  logic        bus_we,
    input  logic        bus_fill,
    input  logic [11:0] bus_addr,
    input  logic [31:0] bus_data,
    input  logic [10:0] bus_count,
    output logic [31:0] bus_q,
    output logic        busy,
    output logic        done,
    input  logic        ontile_v,
    output logic [10:0] vram32_addr,
    output logic [31:0] vram32_d,
    output logic        vram32_we,
    input  logic [31:0] vram32_q,
    output logic [10:0] vram8_addr,
    output logic [7:0]  vram8_d,
    output logic        vram8_we,
    input  logic [7:0]  vram8_q
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_RCAP  = 3'd3,
        ST_FILL  = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        sel_r;        // latched target: 1 = VRAM8
    logic [10:0] cnt_r;        // remaining fill beats
    logic        stall_s;
    logic        beat_s;
    logic        accept_s;
    logic        load_addr_s;
    logic        load_d_s;
    logic        advance_s;
    logic        capture_s;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic, beat qualification and datapath load controls.
    always_comb begin
        state_s     = state_r;
        beat_s      = 1'b0;
        stall_s     = SYNC_VBLANK & ontile_v;
        accept_s    = 1'b0;
        load_addr_s = 1'b0;
        load_d_s    = 1'b0;
        advance_s   = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus_start) begin
                    accept_s = 1'b1;
                    if (bus_fill) begin
                        state_s = ST_FILL;
                    end else if (bus_we) begin
                        state_s = ST_WRITE;
                    end else begin
                        state_s = ST_READ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (stall_s) begin
                    state_s = ST_WRITE;
                end else begin
                    beat_s  = 1'b1;
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                state_s = ST_RCAP;
            end
            ST_RCAP: begin
                capture_s = 1'b1;
                state_s   = ST_IDLE;
            end
            ST_FILL: begin
                // A zero-length fill spends one busy cycle here and writes nothing.
                if (cnt_r == 11'd0) begin
                    state_s = ST_IDLE;
                end else if (stall_s) begin
                    state_s = ST_FILL;
                end else begin
                    beat_s = 1'b1;
                    if (cnt_r == 11'd1) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s   = ST_FILL;
                        advance_s = 1'b1;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // A zero-length fill leaves the port outputs untouched, so they keep
        // showing the last real beat.
        if (accept_s) begin
            if (bus_fill) begin
                load_addr_s = (bus_count != 11'd0);
                load_d_s    = (bus_count != 11'd0);
            end else begin
                load_addr_s = 1'b1;
                load_d_s    = bus_we;
            end
        end else begin
            load_addr_s = 1'b0;
            load_d_s    = 1'b0;
        end
    end

    // The write enables follow the beat decision combinationally. A vblank
    // stall must suppress the enable in the same cycle that ontile_v rises.
    // A registered enable would always lag by one cycle. After reset the
    // state is IDLE, so both enables are low.
    assign vram32_we = beat_s & ~sel_r;
    assign vram8_we  = beat_s &  sel_r;

    // Handshake status, target select and fill down-counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            sel_r <= 1'b0;
            cnt_r <= 11'd0;
        end else begin
            busy <= (state_s != ST_IDLE);
            done <= (state_r != ST_IDLE) && (state_s == ST_IDLE);
            if (accept_s) begin
                sel_r <= bus_addr[11];
                cnt_r <= bus_count;
            end else if ((state_r == ST_FILL) && beat_s) begin
                cnt_r <= cnt_r - 11'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Memory port address/data registers and the read-result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vram32_addr <= 11'd0;
            vram32_d    <= 32'd0;
            vram8_addr  <= 11'd0;
            vram8_d     <= 8'd0;
            bus_q       <= 32'd0;
        end else begin
            // The address always points at the pending beat. It moves only
            // after a beat that is not the last one, so it holds through
            // stalls and keeps the final beat's address afterwards. The
            // increment wraps within 11 bits.
            if (load_addr_s && !bus_addr[11]) begin
                vram32_addr <= bus_addr[10:0];
            end else if (advance_s && !sel_r) begin
                vram32_addr <= vram32_addr + 11'd1;
            end else begin
                vram32_addr <= vram32_addr;
            end

            if (load_addr_s && bus_addr[11]) begin
                vram8_addr <= bus_addr[10:0];
            end else if (advance_s && sel_r) begin
                vram8_addr <= vram8_addr + 11'd1;
            end else begin
                vram8_addr <= vram8_addr;
            end

            if (load_d_s && !bus_addr[11]) begin
                vram32_d <= bus_data;
            end else begin
                vram32_d <= vram32_d;
            end

            if (load_d_s && bus_addr[11]) begin
                vram8_d <= bus_data[7:0];
            end else begin
                vram8_d <= vram8_d;
            end

            if (capture_s) begin
                bus_q <= sel_r ? {24'd0, vram8_q} : vram32_q;
            end else begin
                bus_q <= bus_q;
            end
        end
    end

endmodule

// File: tb/tb_vram_bus_writer.sv
// -----------------------------------------------------------------------------
// tb_vram_bus_writer
//
// This bench drives two instances from a table of requests: one with vblank
// sync off and one with it on. A small synchronous RAM model sits behind each
// instance's ports. Hand-written sequences cover the multi-cycle cases:
// asynchronous reset in mid-cycle, reset during a fill, and recovery after
// reset.
// -----------------------------------------------------------------------------
module tb_vram_bus_writer;

    typedef struct packed {
        logic        sync;
        logic        fill;
        logic        we;
        logic [11:0] addr;
        logic [31:0] data;
        logic [10:0] cnt;
        logic [15:0] ontile;     // bit k: ontile_v high in cycle N+k
        logic        restart;    // hold bus_start high while busy
        logic [7:0]  exp_done;   // cycle N+k that carries done
        logic [15:0] exp_mask;   // bit k: write beat in cycle N+k
        logic [10:0] exp_first;
        logic [10:0] exp_last;
        logic        chk_q;
        logic [31:0] exp_q;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        bus_start;
    logic        bus_start_s;
    logic        bus_we;
    logic        bus_fill;
    logic [11:0] bus_addr;
    logic [31:0] bus_data;
    logic [10:0] bus_count;
    logic        ontile_v;

    logic [31:0] a_q, s_q;
    logic        a_busy, a_done, s_busy, s_done;
    logic [10:0] a_a32, a_a8, s_a32, s_a8;
    logic [31:0] a_d32, s_d32, a_q32, s_q32;
    logic [7:0]  a_d8, s_d8, a_q8, s_q8;
    logic        a_we32, a_we8, s_we32, s_we8;

    logic [31:0] mem32_a [2048];
    logic [7:0]  mem8_a  [2048];
    logic [31:0] mem32_s [2048];
    logic [7:0]  mem8_s  [2048];

    logic        tsel;
    logic        o_busy, o_done, o_we32, o_we8;
    logic [10:0] o_a32, o_a8;
    logic [31:0] o_d32, o_q;
    logic [7:0]  o_d8;

    int n_chk;
    int n_fail;
    vec_t tbl [16];

    vram_bus_writer #(.SYNC_VBLANK(1'b0)) dut (
        .clk(clk), .reset(reset), .bus_start(bus_start), .bus_we(bus_we),
        .bus_fill(bus_fill), .bus_addr(bus_addr), .bus_data(bus_data),
        .bus_count(bus_count), .bus_q(a_q), .busy(a_busy), .done(a_done),
        .ontile_v(ontile_v), .vram32_addr(a_a32), .vram32_d(a_d32),
        .vram32_we(a_we32), .vram32_q(a_q32), .vram8_addr(a_a8),
        .vram8_d(a_d8), .vram8_we(a_we8), .vram8_q(a_q8)
    );

    vram_bus_writer #(.SYNC_VBLANK(1'b1)) dut_s (
        .clk(clk), .reset(reset), .bus_start(bus_start_s), .bus_we(bus_we),
        .bus_fill(bus_fill), .bus_addr(bus_addr), .bus_data(bus_data),
        .bus_count(bus_count), .bus_q(s_q), .busy(s_busy), .done(s_done),
        .ontile_v(ontile_v), .vram32_addr(s_a32), .vram32_d(s_d32),
        .vram32_we(s_we32), .vram32_q(s_q32), .vram8_addr(s_a8),
        .vram8_d(s_d8), .vram8_we(s_we8), .vram8_q(s_q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM models, q valid one cycle after the address.
    always @(posedge clk) begin
        if (a_we32) mem32_a[a_a32] <= a_d32;
        if (a_we8)  mem8_a[a_a8]   <= a_d8;
        if (s_we32) mem32_s[s_a32] <= s_d32;
        if (s_we8)  mem8_s[s_a8]   <= s_d8;
        a_q32 <= mem32_a[a_a32];
        a_q8  <= mem8_a[a_a8];
        s_q32 <= mem32_s[s_a32];
        s_q8  <= mem8_s[s_a8];
    end

    // Observe whichever instance the current request targets.
    always_comb begin
        if (tsel) begin
            o_busy = s_busy; o_done = s_done; o_we32 = s_we32; o_we8 = s_we8;
            o_a32 = s_a32; o_a8 = s_a8; o_d32 = s_d32; o_d8 = s_d8; o_q = s_q;
        end else begin
            o_busy = a_busy; o_done = a_done; o_we32 = a_we32; o_we8 = a_we8;
            o_a32 = a_a32; o_a8 = a_a8; o_d32 = a_d32; o_d8 = a_d8; o_q = a_q;
        end
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Issue one request and record what the memory ports do until done.
    task automatic run_op(input vec_t v, output int done_at, output logic [15:0] bmask,
                          output logic [10:0] first, output logic [10:0] last,
                          output logic [31:0] q, output bit dok, output bit sok,
                          output bit tok, output bit bok, output bit pok);
        int nb;
        logic [10:0] cur;
        logic [10:0] nxt;
        logic [31:0] dact;
        logic [31:0] dexp;
        done_at = -1; bmask = 16'h0; first = 11'h0; last = 11'h0; q = 32'h0;
        dok = 1'b1; sok = 1'b1; tok = 1'b1; bok = 1'b1; pok = 1'b1; nb = 0;
        tsel = v.sync;
        dexp = v.addr[11] ? {24'd0, v.data[7:0]} : v.data;
        @(posedge clk); #1;
        bus_fill = v.fill; bus_we = v.we; bus_addr = v.addr; bus_data = v.data;
        bus_count = v.cnt; ontile_v = 1'b0;
        if (v.sync) bus_start_s = 1'b1; else bus_start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(posedge clk);
            #1;
            ontile_v = (k < 16) ? v.ontile[k] : 1'b0;
            if (v.sync) bus_start_s = v.restart && (k < int'(v.exp_done));
            else        bus_start   = v.restart && (k < int'(v.exp_done));
            if (k == 1) begin
                // Scramble request fields so a late or repeated latch shows up.
                bus_addr = v.addr ^ 12'h555; bus_data = ~v.data; bus_count = 11'd7;
            end
            #1;
            if (o_done) begin
                done_at = k; q = o_q;
                if (o_busy || o_we32 || o_we8) bok = 1'b0;
                break;
            end
            if (!o_busy) bok = 1'b0;
            if (o_we32 || o_we8) begin
                if ((o_we32 && o_we8) || (o_we8 != v.addr[11])) tok = 1'b0;
                cur  = v.addr[11] ? o_a8 : o_a32;
                dact = v.addr[11] ? {24'd0, o_d8} : o_d32;
                if (dact !== dexp) dok = 1'b0;
                nxt = last + 11'd1;
                if (nb == 0) first = cur;
                else if (cur !== nxt) sok = 1'b0;
                last = cur;
                nb++;
                if (k < 16) bmask[k] = 1'b1;
            end
        end
        bus_start = 1'b0; bus_start_s = 1'b0; ontile_v = 1'b0;
        if (done_at > 0) begin
            @(posedge clk); #2;
            pok = !o_done;
        end
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        int done_at;
        logic [15:0] bm;
        logic [10:0] f, l;
        logic [31:0] q;
        bit dok, sok, tok, bok, pok;
        run_op(v, done_at, bm, f, l, q, dok, sok, tok, bok, pok);
        chk({tag, " done cycle"}, done_at, {24'd0, v.exp_done});
        chk({tag, " beat cycles"}, {16'd0, bm}, {16'd0, v.exp_mask});
        if (v.exp_mask != 16'h0) begin
            chk({tag, " first addr"}, {21'd0, f}, {21'd0, v.exp_first});
            chk({tag, " last addr"}, {21'd0, l}, {21'd0, v.exp_last});
            chk({tag, " beat data"}, {31'd0, dok}, 32'd1);
            chk({tag, " addr sequence"}, {31'd0, sok}, 32'd1);
        end
        chk({tag, " target we"}, {31'd0, tok}, 32'd1);
        chk({tag, " busy"}, {31'd0, bok}, 32'd1);
        chk({tag, " done pulse"}, {31'd0, pok}, 32'd1);
        if (v.chk_q) chk({tag, " bus_q"}, q, v.exp_q);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int nd;
        vec_t vx;
        n_chk = 0; n_fail = 0; tsel = 1'b0;
        reset = 1'b1; bus_start = 1'b0; bus_start_s = 1'b0; bus_we = 1'b0;
        bus_fill = 1'b0; bus_addr = 12'h0; bus_data = 32'h0; bus_count = 11'd0;
        ontile_v = 1'b0;

        //          sync  fill  we    addr     data          cnt    ontile    rst   done  mask      first   last    chkq  q
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 12'h400, 32'hE0E01C03, 11'd0, 16'h0000, 1'b0, 8'd2, 16'h0002, 11'h400, 11'h400, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 12'hB80, 32'hFFFFFF5A, 11'd0, 16'h0000, 1'b0, 8'd2, 16'h0002, 11'h380, 11'h380, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 12'hB80, 32'h00000000, 11'd0, 16'h0000, 1'b0, 8'd3, 16'h0000, 11'h000, 11'h000, 1'b1, 32'h0000005A};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 12'hFFE, 32'h12345677, 11'd4, 16'h0000, 1'b1, 8'd5, 16'h001E, 11'h7FE, 11'h001, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 12'h400, 32'h00000000, 11'd0, 16'h0000, 1'b0, 8'd3, 16'h0000, 11'h000, 11'h000, 1'b1, 32'hE0E01C03};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 12'hFFF, 32'h00000000, 11'd0, 16'h0000, 1'b0, 8'd3, 16'h0000, 11'h000, 11'h000, 1'b1, 32'h00000077};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 12'h801, 32'h00000000, 11'd0, 16'h0000, 1'b0, 8'd3, 16'h0000, 11'h000, 11'h000, 1'b1, 32'h00000077};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 12'h010, 32'h55555555, 11'd0, 16'h0000, 1'b0, 8'd2, 16'h0000, 11'h000, 11'h000, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 12'h7FF, 32'hDEADBEEF, 11'd1, 16'h0000, 1'b0, 8'd2, 16'h0002, 11'h7FF, 11'h7FF, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 12'h020, 32'h11111111, 11'd2, 16'h0000, 1'b0, 8'd3, 16'h0006, 11'h020, 11'h021, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 12'h7F0, 32'h0BADCAFE, 11'd0, 16'h003E, 1'b0, 8'd2, 16'h0002, 11'h7F0, 11'h7F0, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 12'h7FF, 32'h00000000, 11'd0, 16'h0000, 1'b0, 8'd3, 16'h0000, 11'h000, 11'h000, 1'b1, 32'hDEADBEEF};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 12'h100, 32'hCAFEF00D, 11'd3, 16'h001C, 1'b0, 8'd7, 16'h0062, 11'h100, 11'h102, 1'b0, 32'h0};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 12'h840, 32'h000000A5, 11'd0, 16'h0006, 1'b0, 8'd4, 16'h0008, 11'h040, 11'h040, 1'b0, 32'h0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 12'h100, 32'h00000000, 11'd0, 16'h000E, 1'b0, 8'd3, 16'h0000, 11'h000, 11'h000, 1'b1, 32'hCAFEF00D};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 12'h840, 32'h00000000, 11'd0, 16'h0002, 1'b0, 8'd3, 16'h0000, 11'h000, 11'h000, 1'b1, 32'h000000A5};

        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", {31'd0, a_busy}, 32'd0);
        chk("reset done", {31'd0, a_done}, 32'd0);
        chk("reset we", {30'd0, a_we32, a_we8}, 32'd0);
        chk("reset bus_q", a_q, 32'd0);
        #1 reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            check_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Asynchronous reset in mid-cycle, during a write beat.
        tsel = 1'b0;
        @(posedge clk); #1;
        bus_fill = 1'b0; bus_we = 1'b1; bus_addr = 12'h8AB; bus_data = 32'h000000FF;
        bus_start = 1'b1;
        @(posedge clk); #1 bus_start = 1'b0;
        #1 chk("async pre we8", {31'd0, o_we8}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async busy", {31'd0, o_busy}, 32'd0);
        chk("async done", {31'd0, o_done}, 32'd0);
        chk("async we", {30'd0, o_we32, o_we8}, 32'd0);
        chk("async addr32", {21'd0, o_a32}, 32'd0);
        chk("async addr8", {21'd0, o_a8}, 32'd0);
        chk("async d32", o_d32, 32'd0);
        chk("async d8", {24'd0, o_d8}, 32'd0);
        chk("async bus_q", o_q, 32'd0);
        #1 reset = 1'b0;

        // Reset in the middle of a 10-word fill, after three beats.
        @(posedge clk); #1;
        bus_fill = 1'b1; bus_we = 1'b1; bus_addr = 12'h200; bus_data = 32'h0F0F0F0F;
        bus_count = 11'd10; bus_start = 1'b1;
        @(posedge clk); #1 bus_start = 1'b0;
        nb = 0;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            #1;
            if (o_we32) nb++;
        end
        chk("midfill beats before reset", nb, 32'd3);
        @(posedge clk); #1 reset = 1'b1;
        #1 reset = 1'b0;
        nb = 0; nd = 0;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) begin @(posedge clk); #2; end
            else #1;
            if (o_we32 || o_we8) nb++;
            if (o_done) nd++;
        end
        chk("midfill beats after reset", nb, 32'd0);
        chk("midfill done after reset", nd, 32'd0);
        chk("midfill busy after reset", {31'd0, o_busy}, 32'd0);

        // Normal operation after the abandoned fill.
        vx = '{1'b0, 1'b0, 1'b1, 12'h300, 32'h13579BDF, 11'd0, 16'h0000, 1'b0, 8'd2, 16'h0002, 11'h300, 11'h300, 1'b0, 32'h0};
        check_vec("post-reset write", vx);
        vx = '{1'b0, 1'b0, 1'b0, 12'h300, 32'h00000000, 11'd0, 16'h0000, 1'b0, 8'd3, 16'h0000, 11'h000, 11'h000, 1'b1, 32'h13579BDF};
        check_vec("post-reset read", vx);
        vx = '{1'b0, 1'b1, 1'b1, 12'h900, 32'h00000077, 11'd0, 16'h0000, 1'b0, 8'd2, 16'h0000, 11'h000, 11'h000, 1'b0, 32'h0};
        check_vec("post-reset fill0", vx);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_bus_writer.md
# vram_bus_writer

CPU-side access port for the two graphics memories (VRAM32: patterns/palettes, VRAM8: name/palette-index tables) whose other ports are read continuously by the frame synthesizer. It accepts single-word read/write requests and block-fill requests over a start/busy/done handshake and drives the write port of each VRAM. It optionally defers writes to the vertical non-tile region, using the synthesizer's `ontile_v` output, to avoid tearing.

## Interface
- `SYNC_VBLANK`, default 0: when 1, write beats are issued only while `ontile_v` = 0.
- `clk` in 1: system clock, single clock domain.
- `reset` in 1: asynchronous, active-high.
- `bus_start` in 1: request strobe. Sampled only in IDLE.
- `bus_we` in 1: 1 = write, 0 = read. Ignored when `bus_fill` = 1.
- `bus_fill` in 1: 1 = block fill. Implies write.
- `bus_addr` in 12: bit 11 selects the target (0 = VRAM32, 1 = VRAM8). Bits [10:0] are the word address, or the base address for a fill.
- `bus_data` in 32: write/fill data. VRAM8 uses `[7:0]`.
- `bus_count` in 11: fill length in words. 0 means no writes.
- `bus_q` out 32: read result. VRAM8 reads are zero-extended.
- `busy` out 1: high in every non-IDLE cycle.
- `done` out 1: one-cycle completion pulse.
- `ontile_v` in 1: from the frame synthesizer. High while the display is on tile rows.
- `vram32_addr` out 11, `vram32_d` out 32, `vram32_we` out 1, `vram32_q` in 32: VRAM32 port. Synchronous RAM, q valid 1 cycle after address.
- `vram8_addr` out 11, `vram8_d` out 8, `vram8_we` out 1, `vram8_q` in 8: VRAM8 port. Same timing as VRAM32.

## Operation
- Request latches: on a `clk` edge in IDLE with `bus_start` = 1, the block latches sel, addr, data, count and op.
- States:
  - IDLE: idle. Transitions to WRITE, READ or FILL on an accepted start.
  - WRITE: one write beat, then IDLE.
  - READ: drive the address.
  - RCAP: capture `vramX_q` into `bus_q`, then IDLE.
  - FILL: one beat per cycle; a down-counter tracks remaining beats. Exits to IDLE after the last beat.
- A fill with count = 0 goes directly to IDLE without writing anything.
- Fill addresses: base, base+1, … base+count−1. Arithmetic is 11-bit and wraps 0x7FF→0x000 within the selected VRAM. The data value is the same for every beat.
- Write enables:
  - Exactly one of `vram32_we`/`vram8_we` may be high in a cycle, and only for the selected target.
  - The enable is high only in a cycle that issues a beat.
- Outputs outside beats: `vramX_addr`/`vramX_d` are registered and hold their last value between beats. The unselected port's outputs remain unchanged.
- `SYNC_VBLANK` = 1:
  - In WRITE/FILL, any cycle with `ontile_v` = 1 is a stall cycle: no beat, `we` = 0, address and count held. The operation resumes on the first cycle with `ontile_v` = 0.
  - Reads never stall.
- `SYNC_VBLANK` = 0: `ontile_v` is ignored.
- `bus_start` while busy: ignored and not queued.
- Reset, asserted at any time: state goes to IDLE immediately. All outputs go to 0: `busy`, `done`, both `we`, both `addr`, both `d`, `bus_q`. An in-flight operation is abandoned with no `done`.

## Timing
- Start is accepted at edge N.
- Write: beat in cycle N+1. `done` = 1 and `busy` = 0 in cycle N+2.
- Read: address driven in N+1, q captured at the end of N+2. `bus_q` is valid from N+3 and holds until the next read completes. `done` = 1 in N+3.
- Fill of length C (no stalls): beats in N+1…N+C. `done` in N+C+1. Each stall cycle adds 1.
- Count 0: `done` in N+2 and `busy` = 1 in N+1.
- `done` is high for exactly one cycle, the first IDLE cycle after the operation. A `bus_start` in that same cycle is accepted.

## Test plan
- Reset check: `reset` pulse mid-cycle → all outputs 0 asynchronously, before the next edge.
- Single write: write VRAM32 addr 0x400 data 0xE0E0_1C03 → `vram32_we` high only in N+1 with addr 0x400 and that data. `vram8_we` stays 0. `done` in N+2.
- Single read: VRAM8 read addr 0x380 with the model returning 0x5A → `bus_q` = 0x0000_005A and `done` in N+3.
- Wrapping fill: VRAM8 fill base 0x7FE, count 4, data 0x..77 → beats at 0x7FE, 0x7FF, 0x000, 0x001, each with d = 0x77. `done` at N+5. A `bus_start` during the fill is ignored.
- Vblank sync: `SYNC_VBLANK` = 1, fill count 3 with `ontile_v` high for cycles N+2…N+4 → beats in N+1, N+5, N+6. No `we` during the stall. `done` in N+7.
- Reset mid-fill, plus edge counts:
  - Reset mid-fill of count 10 after 3 beats → no further beats and no `done`.
  - A fresh write afterwards completes normally.
  - A count-0 fill → no `we`, `done` in N+2.
